debounce_ctrl: RTL

Sequences sampling of a raw push-button input and decides when its level is stable, feeding the debounced counter with a clean level and single-cycle edge strobes. It contains a 2-flop synchronizer, a sample-tick divider and a 4-state acceptance FSM. It sits between the board button pin and the counter's enable/increment input.

---
 rtl/debounce_ctrl_pkg.sv | 21 ++
 rtl/debounce_ctrl_sync_2ff.sv | 26 ++
 rtl/debounce_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/debounce_ctrl_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// the counter-width helper used to size the tick and stability counters.
package debounce_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'b00,
        CHECK_HIGH = 2'b01,
        IDLE_HIGH  = 2'b10,
        CHECK_LOW  = 2'b11
    } state_e;

    // A counter for values 0..value-1 never narrower than one bit.
    function automatic int clog2_min1(input int value);
        if (value <= 1) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

endpackage

// File: rtl/debounce_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous button level into the
// clk domain; both flops clear on the active-low asynchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    // Metastability-hardening shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/debounce_ctrl.sv
// Push-button debouncer: a new level is accepted only after the synchronized
// input holds it for TICK_DIV*STABLE_TICKS consecutive cycles.
module debounce_ctrl
    import debounce_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 250000,
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int TW = clog2_min1(TICK_DIV);
    localparam int SW = clog2_min1(STABLE_TICKS);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

    logic          sync_s;
    state_e        state_q;
    logic [TW-1:0] tick_q;
    logic [SW-1:0] stable_q;
    logic          db_level_q;
    logic          rise_q;
    logic          fall_q;
    logic          busy_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (btn_in),
        .q_o   (sync_s)
    );

    // Acceptance FSM with tick divider; all outputs registered alongside state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE_LOW;
            tick_q     <= '0;
            stable_q   <= '0;
            db_level_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE_LOW, IDLE_HIGH: begin
                    tick_q   <= '0;
                    stable_q <= '0;
                    if (sync_s != db_level_q) begin
                        state_q <= (state_q == IDLE_LOW) ? CHECK_HIGH : CHECK_LOW;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= state_q;
                        busy_q  <= 1'b0;
                    end
                end
                CHECK_HIGH, CHECK_LOW: begin
                    // Any sample matching the current level aborts with no credit kept.
                    if (sync_s == db_level_q) begin
                        state_q  <= (state_q == CHECK_HIGH) ? IDLE_LOW : IDLE_HIGH;
                        tick_q   <= '0;
                        stable_q <= '0;
                        busy_q   <= 1'b0;
                    end else if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (stable_q == STABLE_LAST) begin
                            stable_q   <= '0;
                            busy_q     <= 1'b0;
                            db_level_q <= sync_s;
                            rise_q     <= sync_s;
                            fall_q     <= ~sync_s;
                            state_q    <= (state_q == CHECK_HIGH) ? IDLE_HIGH : IDLE_LOW;
                        end else begin
                            stable_q <= stable_q + SW'(1);
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE_LOW;
                    tick_q     <= '0;
                    stable_q   <= '0;
                    db_level_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign db_level   = db_level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

endmodule
